// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped D-cache line store and its flush engine.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } flush_state_t;

    localparam logic FLUSH_WB_INV = 1'b0;
    localparam logic FLUSH_INV    = 1'b1;

    function automatic int calc_words(input int off_bits);
        return 1 << off_bits;
    endfunction

    function automatic int calc_line_w(input int tag_bits, input int off_bits);
        return tag_bits + 32 * calc_words(off_bits);
    endfunction

endpackage

// File: rtl/dcache_flush_fsm.sv
// Flush engine: walks every line, presents dirty lines on the write-back handshake, clears valid/dirty.
// Write-back counter present only when DCACHE_WB_COUNT_EN is defined.
module dcache_flush_fsm
    import dcache_pkg::*;
#(
    parameter int INDEX_SIZE = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush_req,
    input  logic                  flush_mode,
    input  logic                  line_valid,
    input  logic                  line_dirty,
    input  logic                  wb_ready,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    output logic                  clr_en,
    output logic [INDEX_SIZE-1:0] scan_index,
    output logic [INDEX_SIZE:0]   wb_count
);

    // One extra bit so the last-line compare never wraps.
    localparam logic [INDEX_SIZE:0] LAST_IDX = {1'b0, {INDEX_SIZE{1'b1}}};

    flush_state_t          state_reg, state_next;
    logic [INDEX_SIZE:0]   scan_idx_reg, scan_idx_next;
    logic                  mode_reg, mode_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            scan_idx_reg <= '0;
            mode_reg     <= FLUSH_WB_INV;
        end else begin
            state_reg    <= state_next;
            scan_idx_reg <= scan_idx_next;
            mode_reg     <= mode_next;
        end
    end

    // Kept outside the next-state block so the read mux does not form a false loop.
    assign flush_busy = (state_reg != IDLE);
    assign flush_done = (state_reg == DONE);
    assign scan_index = scan_idx_reg[INDEX_SIZE-1:0];

    always_comb begin
        state_next    = state_reg;
        scan_idx_next = scan_idx_reg;
        mode_next     = mode_reg;
        wb_valid      = 1'b0;
        clr_en        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next    = SCAN;
                    scan_idx_next = '0;
                    mode_next     = flush_mode;
                end
            end
            SCAN: begin
                wb_valid = line_valid && line_dirty && (mode_reg == FLUSH_WB_INV);
                if (!wb_valid || wb_ready) begin
                    clr_en = 1'b1;
                    if (scan_idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        scan_idx_next = scan_idx_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef DCACHE_WB_COUNT_EN
    logic [INDEX_SIZE:0] count_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (state_reg == IDLE && flush_req) begin
            count_reg <= '0;
        end else if (wb_valid && wb_ready) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign wb_count = count_reg;
`else
    assign wb_count = '0;
`endif

endmodule

// File: rtl/dcache_line_store.sv
// Direct-mapped D-cache line store: tag/data in distributed RAM, valid/dirty vectors, flush engine.
// Optional macro DCACHE_WB_COUNT_EN enables the write-back counter on wb_count.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_SIZE    = 6,
    parameter int WORD_OFF_SIZE = 4,
    parameter int TAG_SIZE      = 20,
    localparam int WORDS        = calc_words(WORD_OFF_SIZE),
    localparam int LINES        = 2 ** INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [INDEX_SIZE-1:0] rd_index,
    output logic [TAG_SIZE-1:0]   rd_tag,
    output logic [32*WORDS-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic                  wr_en,
    input  logic [INDEX_SIZE-1:0] wr_index,
    input  logic [TAG_SIZE-1:0]   wr_tag,
    input  logic [32*WORDS-1:0]   wr_data,
    input  logic [WORDS-1:0]      wr_word_en,
    input  logic                  wr_dv_en,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic                  flush_req,
    input  logic                  flush_mode,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [INDEX_SIZE-1:0] wb_index,
    output logic [TAG_SIZE-1:0]   wb_tag,
    output logic [32*WORDS-1:0]   wb_data,
    output logic [INDEX_SIZE:0]   wb_count
);

    logic [INDEX_SIZE-1:0] scan_index;
    logic [INDEX_SIZE-1:0] rd_idx;
    logic                  clr_en;
    logic                  wr_ok;
    logic [LINES-1:0]      valid_reg;
    logic [LINES-1:0]      dirty_reg;
    logic [TAG_SIZE-1:0]   tag_mem [LINES];

    assign rd_idx = flush_busy ? scan_index : rd_index;
    assign wr_ok  = wr_en && !flush_busy;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end
    assign rd_tag = tag_mem[rd_idx];

    // One RAM column per word so each word lane has its own write enable.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            logic [31:0] word_mem [LINES];

            always_ff @(posedge clk) begin
                if (wr_ok && wr_word_en[gi]) begin
                    word_mem[wr_index] <= wr_data[32*gi +: 32];
                end
            end
            assign rd_data[32*gi +: 32] = word_mem[rd_idx];
        end
    endgenerate

    // Client DV writes never collide with flush clears: they are blocked while busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (clr_en) begin
            valid_reg[scan_index] <= 1'b0;
            dirty_reg[scan_index] <= 1'b0;
        end else if (wr_dv_en && !flush_busy) begin
            valid_reg[wr_index] <= wr_valid;
            dirty_reg[wr_index] <= wr_dirty;
        end
    end
    assign rd_valid = valid_reg[rd_idx];
    assign rd_dirty = dirty_reg[rd_idx];

    assign wb_index = scan_index;
    assign wb_tag   = rd_tag;
    assign wb_data  = rd_data;

    dcache_flush_fsm #(
        .INDEX_SIZE (INDEX_SIZE)
    ) u_flush_fsm (
        .clk        (clk),
        .resetn     (resetn),
        .flush_req  (flush_req),
        .flush_mode (flush_mode),
        .line_valid (rd_valid),
        .line_dirty (rd_dirty),
        .wb_ready   (wb_ready),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .wb_valid   (wb_valid),
        .clr_en     (clr_en),
        .scan_index (scan_index),
        .wb_count   (wb_count)
    );

endmodule
